// File: rtl/mem_unit.sv
// Memory stage behind execute: runs one handshaked data-memory access at a time,
// stalls upstream while it is outstanding, and emits a one-cycle writeback or return-address packet.
module mem_unit #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic        flush,
    input  logic        mem_to_reg_in,
    input  logic        reg_to_mem_in,
    input  logic        ret_future_in,
    input  logic [3:0]  reg_rd_in,
    input  logic [15:0] alu_result,
    input  logic [15:0] sw_data,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        stall,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [15:0] wb_data,
    output logic [3:0]  reg_rd_out,
    output logic        ret_wb,
    output logic [15:0] PC_stack_pointer,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    // The abort fires on the wait cycle that would bring the counter up to MEM_TIMEOUT.
    localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state_r, state_s;
    logic [7:0]  cnt_r, cnt_s;
    logic        ret_future_r, ret_future_s;
    logic [3:0]  pend_rd_r, pend_rd_s;
    logic [15:0] mem_addr_r, mem_addr_s;
    logic [15:0] mem_wdata_r, mem_wdata_s;
    logic        mem_req_r, mem_req_s;
    logic        mem_we_r, mem_we_s;
    logic        stall_r, stall_s;
    logic        wb_valid_r, wb_valid_s;
    logic        wb_we_r, wb_we_s;
    logic [15:0] wb_data_r, wb_data_s;
    logic [3:0]  reg_rd_r, reg_rd_s;
    logic        ret_wb_r, ret_wb_s;
    logic [15:0] pc_sp_r, pc_sp_s;
    logic        mem_err_r, mem_err_s;

    // Next-state, access bookkeeping and next output packet.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        ret_future_s = ret_future_r;
        pend_rd_s    = pend_rd_r;
        mem_addr_s   = mem_addr_r;
        mem_wdata_s  = mem_wdata_r;
        wb_valid_s   = 1'b0;
        wb_we_s      = 1'b0;
        wb_data_s    = wb_data_r;
        reg_rd_s     = reg_rd_r;
        ret_wb_s     = 1'b0;
        pc_sp_s      = pc_sp_r;
        mem_err_s    = 1'b0;

        case (state_r)
            IDLE: begin
                if (valid_in && !flush) begin
                    if (mem_to_reg_in) begin
                        mem_addr_s   = alu_result;
                        pend_rd_s    = reg_rd_in;
                        ret_future_s = ret_future_in;
                        cnt_s        = 8'd0;
                        state_s      = RD_WAIT;
                    end else if (reg_to_mem_in) begin
                        mem_addr_s  = alu_result;
                        mem_wdata_s = sw_data;
                        cnt_s       = 8'd0;
                        state_s     = WR_WAIT;
                    end else begin
                        wb_valid_s = 1'b1;
                        wb_we_s    = 1'b1;
                        wb_data_s  = alu_result;
                        reg_rd_s   = reg_rd_in;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RD_WAIT: begin
                if (mem_ready) begin
                    state_s    = IDLE;
                    wb_valid_s = 1'b1;
                    if (ret_future_r) begin
                        ret_wb_s = 1'b1;
                        pc_sp_s  = mem_rdata;
                    end else begin
                        wb_we_s   = 1'b1;
                        wb_data_s = mem_rdata;
                        reg_rd_s  = pend_rd_r;
                    end
                end else if (cnt_r == CNT_LAST) begin
                    state_s    = IDLE;
                    wb_valid_s = 1'b1;
                    mem_err_s  = 1'b1;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            WR_WAIT: begin
                if (mem_ready) begin
                    state_s    = IDLE;
                    wb_valid_s = 1'b1;
                end else if (cnt_r == CNT_LAST) begin
                    state_s    = IDLE;
                    wb_valid_s = 1'b1;
                    mem_err_s  = 1'b1;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // Handshake outputs are registered copies of the state decode, so nothing combinational reaches upstream.
        mem_req_s = (state_s != IDLE);
        mem_we_s  = (state_s == WR_WAIT);
        stall_s   = (state_s != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= 8'd0;
            ret_future_r <= 1'b0;
            pend_rd_r    <= 4'd0;
            mem_addr_r   <= 16'd0;
            mem_wdata_r  <= 16'd0;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            stall_r      <= 1'b0;
            wb_valid_r   <= 1'b0;
            wb_we_r      <= 1'b0;
            wb_data_r    <= 16'd0;
            reg_rd_r     <= 4'd0;
            ret_wb_r     <= 1'b0;
            pc_sp_r      <= 16'd0;
            mem_err_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            ret_future_r <= ret_future_s;
            pend_rd_r    <= pend_rd_s;
            mem_addr_r   <= mem_addr_s;
            mem_wdata_r  <= mem_wdata_s;
            mem_req_r    <= mem_req_s;
            mem_we_r     <= mem_we_s;
            stall_r      <= stall_s;
            wb_valid_r   <= wb_valid_s;
            wb_we_r      <= wb_we_s;
            wb_data_r    <= wb_data_s;
            reg_rd_r     <= reg_rd_s;
            ret_wb_r     <= ret_wb_s;
            pc_sp_r      <= pc_sp_s;
            mem_err_r    <= mem_err_s;
        end
    end

    assign mem_req          = mem_req_r;
    assign mem_we           = mem_we_r;
    assign mem_addr         = mem_addr_r;
    assign mem_wdata        = mem_wdata_r;
    assign stall            = stall_r;
    assign wb_valid         = wb_valid_r;
    assign wb_we            = wb_we_r;
    assign wb_data          = wb_data_r;
    assign reg_rd_out       = reg_rd_r;
    assign ret_wb           = ret_wb_r;
    assign PC_stack_pointer = pc_sp_r;
    assign mem_err          = mem_err_r;

endmodule

// File: tb/tb_mem_unit.sv
// Self-checking bench for mem_unit: directed table, hand sequences for reset/back-to-back,
// and randomized transactions against a transaction-level model.
module tb_mem_unit;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in, flush, mem_to_reg_in, reg_to_mem_in, ret_future_in;
    logic [3:0]  reg_rd_in;
    logic [15:0] alu_result, sw_data, mem_rdata;
    logic        mem_ready;
    logic        mem_req, mem_we, stall, wb_valid, wb_we, ret_wb, mem_err;
    logic [15:0] mem_addr, mem_wdata, wb_data, PC_stack_pointer;
    logic [3:0]  reg_rd_out;

    mem_unit #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .flush(flush),
        .mem_to_reg_in(mem_to_reg_in), .reg_to_mem_in(reg_to_mem_in),
        .ret_future_in(ret_future_in), .reg_rd_in(reg_rd_in),
        .alu_result(alu_result), .sw_data(sw_data), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .stall(stall),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_data(wb_data),
        .reg_rd_out(reg_rd_out), .ret_wb(ret_wb),
        .PC_stack_pointer(PC_stack_pointer), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid, flush, ld, st, ret;
        logic [3:0]  rd;
        logic [15:0] alu, swd, rdata;
        int          k;
        int          e_waits;
        logic        e_wv, e_we, e_ret, e_err;
        logic [15:0] e_data;
        logic [3:0]  e_rd;
        logic [15:0] e_pc;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;

    // held-value model of the writeback packet
    logic [15:0] m_data = 16'd0;
    logic [3:0]  m_rd = 4'd0;
    logic [15:0] m_pc = 16'd0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic valid, input logic fl, input logic ld, input logic st,
                                input logic ret, input logic [3:0] rd, input logic [15:0] alu,
                                input logic [15:0] swd, input int k, input logic [15:0] rdata,
                                input int waits, input logic wv, input logic we, input logic eret,
                                input logic err, input logic [15:0] data, input logic [3:0] erd,
                                input logic [15:0] pc);
        vec_t v;
        v.valid = valid; v.flush = fl; v.ld = ld; v.st = st; v.ret = ret; v.rd = rd;
        v.alu = alu; v.swd = swd; v.k = k; v.rdata = rdata;
        v.e_waits = waits; v.e_wv = wv; v.e_we = we; v.e_ret = eret; v.e_err = err;
        v.e_data = data; v.e_rd = erd; v.e_pc = pc;
        return v;
    endfunction

    // Reference: what one instruction should produce, from the stage's transaction rules.
    function automatic vec_t predict(input vec_t v);
        vec_t e = v;
        e.e_waits = 0; e.e_wv = 1'b0; e.e_we = 1'b0; e.e_ret = 1'b0; e.e_err = 1'b0;
        e.e_data = m_data; e.e_rd = m_rd; e.e_pc = m_pc;
        if (v.valid && !v.flush) begin
            e.e_wv = 1'b1;
            if (v.ld || v.st) begin
                e.e_waits = (v.k < TO) ? v.k : TO;
                if (v.k > TO) e.e_err = 1'b1;
                else if (v.ld && v.ret) begin e.e_ret = 1'b1; e.e_pc = v.rdata; end
                else if (v.ld) begin e.e_we = 1'b1; e.e_data = v.rdata; e.e_rd = v.rd; end
            end else begin
                e.e_we = 1'b1; e.e_data = v.alu; e.e_rd = v.rd;
            end
        end
        return e;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        logic is_st;
        is_st = v.st && !v.ld;
        valid_in = v.valid; flush = v.flush; mem_to_reg_in = v.ld; reg_to_mem_in = v.st;
        ret_future_in = v.ret; reg_rd_in = v.rd; alu_result = v.alu; sw_data = v.swd;
        mem_ready = 1'b1; mem_rdata = 16'hDEAD;   // ready in IDLE must be ignored
        step();
        for (int i = 1; i <= v.e_waits; i++) begin
            chk({tag, " wait stall"}, 16'(stall), 16'd1);
            chk({tag, " wait mem_req"}, 16'(mem_req), 16'd1);
            chk({tag, " wait mem_we"}, 16'(mem_we), 16'(is_st));
            chk({tag, " wait mem_addr"}, mem_addr, v.alu);
            if (is_st) chk({tag, " wait mem_wdata"}, mem_wdata, v.swd);
            valid_in = 1'b1; flush = 1'($urandom_range(0, 1)); alu_result = 16'($urandom);
            mem_ready = (i == v.k); mem_rdata = v.rdata;
            step();
        end
        valid_in = 1'b0; flush = 1'b0; mem_ready = 1'b0;
        chk({tag, " wb_valid"}, 16'(wb_valid), 16'(v.e_wv));
        chk({tag, " wb_we"}, 16'(wb_we), 16'(v.e_we));
        chk({tag, " wb_data"}, wb_data, v.e_data);
        chk({tag, " reg_rd_out"}, 16'(reg_rd_out), 16'(v.e_rd));
        chk({tag, " ret_wb"}, 16'(ret_wb), 16'(v.e_ret));
        chk({tag, " pc_sp"}, PC_stack_pointer, v.e_pc);
        chk({tag, " mem_err"}, 16'(mem_err), 16'(v.e_err));
        chk({tag, " stall"}, 16'(stall), 16'd0);
        chk({tag, " mem_req"}, 16'(mem_req), 16'd0);
        m_data = v.e_data; m_rd = v.e_rd; m_pc = v.e_pc;
    endtask

    vec_t tbl[$];
    vec_t rv;

    initial begin
        rst_n = 1'b0; valid_in = 1'b0; flush = 1'b0; mem_to_reg_in = 1'b0; reg_to_mem_in = 1'b0;
        ret_future_in = 1'b0; reg_rd_in = 4'd0; alu_result = 16'd0; sw_data = 16'd0;
        mem_rdata = 16'd0; mem_ready = 1'b0;
        #12;
        chk("rst mem_req", 16'(mem_req), 16'd0);
        chk("rst stall", 16'(stall), 16'd0);
        chk("rst wb_valid", 16'(wb_valid), 16'd0);
        chk("rst mem_addr", mem_addr, 16'd0);
        chk("rst wb_data", wb_data, 16'd0);
        chk("rst pc_sp", PC_stack_pointer, 16'd0);
        @(negedge clk); rst_n = 1'b1;
        step();

        // back-to-back ALU ops, one packet per cycle
        valid_in = 1'b1; reg_rd_in = 4'd5; alu_result = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("b2b wb_valid", 16'(wb_valid), 16'd1);
            chk("b2b wb_we", 16'(wb_we), 16'd1);
            chk("b2b wb_data", wb_data, 16'h1234);
            chk("b2b reg_rd", 16'(reg_rd_out), 16'd5);
            chk("b2b stall", 16'(stall), 16'd0);
        end
        valid_in = 1'b0;
        step();
        chk("b2b pulse end", 16'(wb_valid), 16'd0);

        // reset in the middle of RD_WAIT
        valid_in = 1'b1; mem_to_reg_in = 1'b1; alu_result = 16'h0777;
        step();
        valid_in = 1'b0; mem_to_reg_in = 1'b0;
        chk("pre-rst mem_req", 16'(mem_req), 16'd1);
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst mem_req", 16'(mem_req), 16'd0);
        chk("midrst stall", 16'(stall), 16'd0);
        chk("midrst mem_addr", mem_addr, 16'd0);
        chk("midrst wb_data", wb_data, 16'd0);
        @(negedge clk); rst_n = 1'b1;
        step();
        chk("postrst stall", 16'(stall), 16'd0);
        m_data = 16'd0; m_rd = 4'd0; m_pc = 16'd0;

        //            v  f  ld st rt rd     alu       swd       k   rdata    w  wv we rt er data      rd     pc
        tbl.push_back(mk(1, 0, 0, 0, 0, 4'd5, 16'h1234, 16'h0000, 1, 16'h0000, 0, 1, 1, 0, 0, 16'h1234, 4'd5, 16'h0000));
        tbl.push_back(mk(1, 1, 1, 0, 0, 4'd8, 16'h0040, 16'h0000, 1, 16'h0000, 0, 0, 0, 0, 0, 16'h1234, 4'd5, 16'h0000));
        tbl.push_back(mk(1, 0, 1, 0, 0, 4'd3, 16'h0040, 16'h0000, 3, 16'hBEEF, 3, 1, 1, 0, 0, 16'hBEEF, 4'd3, 16'h0000));
        tbl.push_back(mk(1, 0, 1, 0, 1, 4'd7, 16'h0100, 16'h0000, 1, 16'h0123, 1, 1, 0, 1, 0, 16'hBEEF, 4'd3, 16'h0123));
        tbl.push_back(mk(1, 0, 0, 1, 0, 4'd9, 16'h0010, 16'h00AA, 1, 16'h0000, 1, 1, 0, 0, 0, 16'hBEEF, 4'd3, 16'h0123));
        tbl.push_back(mk(1, 0, 1, 0, 0, 4'd2, 16'h0200, 16'h0000, 99, 16'h0000, 15, 1, 0, 0, 1, 16'hBEEF, 4'd3, 16'h0123));
        tbl.push_back(mk(0, 0, 1, 0, 0, 4'd2, 16'h0999, 16'h0000, 1, 16'h0000, 0, 0, 0, 0, 0, 16'hBEEF, 4'd3, 16'h0123));
        tbl.push_back(mk(1, 0, 1, 1, 0, 4'd4, 16'h0300, 16'h1111, 2, 16'h5A5A, 2, 1, 1, 0, 0, 16'h5A5A, 4'd4, 16'h0123));
        tbl.push_back(mk(1, 0, 0, 1, 0, 4'd0, 16'h0400, 16'h2222, 15, 16'h0000, 15, 1, 0, 0, 0, 16'h5A5A, 4'd4, 16'h0123));
        tbl.push_back(mk(1, 0, 1, 0, 0, 4'd6, 16'h0500, 16'h0000, 15, 16'h0F0F, 15, 1, 1, 0, 0, 16'h0F0F, 4'd6, 16'h0123));
        tbl.push_back(mk(1, 0, 1, 0, 0, 4'd1, 16'h0600, 16'h0000, 16, 16'h3333, 15, 1, 0, 0, 1, 16'h0F0F, 4'd6, 16'h0123));
        tbl.push_back(mk(1, 0, 0, 1, 0, 4'd1, 16'h0700, 16'h7777, 20, 16'h0000, 15, 1, 0, 0, 1, 16'h0F0F, 4'd6, 16'h0123));
        tbl.push_back(mk(1, 0, 1, 0, 1, 4'd1, 16'h0800, 16'h0000, 16, 16'h4444, 15, 1, 0, 0, 1, 16'h0F0F, 4'd6, 16'h0123));
        tbl.push_back(mk(1, 0, 0, 0, 0, 4'hF, 16'hFFFF, 16'h0000, 1, 16'h0000, 0, 1, 1, 0, 0, 16'hFFFF, 4'hF, 16'h0123));
        for (int i = 0; i < tbl.size(); i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // randomized transactions against the model
        for (int n = 0; n < 150; n++) begin
            int kind;
            kind = $urandom_range(0, 5);
            rv.valid = ($urandom_range(0, 9) != 0);
            rv.flush = ($urandom_range(0, 7) == 0);
            rv.ld    = (kind <= 1) || (kind == 5);
            rv.st    = (kind == 2) || (kind == 5);
            rv.ret   = rv.ld && ($urandom_range(0, 2) == 0);
            rv.rd    = 4'($urandom);
            rv.alu   = 16'($urandom);
            rv.swd   = 16'($urandom);
            rv.rdata = 16'($urandom);
            rv.k     = $urandom_range(1, 18);
            rv = predict(rv);
            run_txn(rv, $sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_unit.md
Name: mem_unit

Overview:
- Memory stage directly downstream of the execute stage.
- Consumes the execute stage's pass-through controls (mem_to_reg, reg_to_mem, ret_future, reg_rd), alu_result (ALU value or memory address) and sw_data.
- Runs a handshaked, multi-cycle data-memory access; stalls upstream while an access is outstanding.
- Delivers a one-cycle writeback packet, or a return-address packet (ret_wb / PC_stack_pointer) back to the PC updater.

Parameters:
MEM_TIMEOUT, 15, maximum wait cycles for mem_ready before the access is aborted (range 1..255)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
valid_in  input  1  execute stage presents a valid instruction
flush  input  1  discard valid_in this cycle
mem_to_reg_in  input  1  load
reg_to_mem_in  input  1  store
ret_future_in  input  1  load is a return-address pop
reg_rd_in  input  4  destination register
alu_result  input  16  ALU value, or address for load/store
sw_data  input  16  store data
mem_rdata  input  16  read data from memory
mem_ready  input  1  memory completes the current request
mem_req  output  1  request active
mem_we  output  1  1 = write
mem_addr  output  16  registered address
mem_wdata  output  16  registered store data
stall  output  1  upstream must hold its outputs
wb_valid  output  1  writeback packet valid (1-cycle pulse)
wb_we  output  1  register-file write enable for the packet
wb_data  output  16  writeback value
reg_rd_out  output  4  writeback destination
ret_wb  output  1  return address ready (1-cycle pulse)
PC_stack_pointer  output  16  popped return address
mem_err  output  1  timeout abort (1-cycle pulse)

Behaviour:
- Clocking: single clock domain on clk.
- Reset (rst_n low, async): state IDLE, timeout counter 0, every output 0. Reset during RD_WAIT/WR_WAIT drops mem_req immediately and loses the access.
- States: IDLE, RD_WAIT, WR_WAIT.
- stall = (state != IDLE), decoded from registered state only; no combinational path from valid_in.
- mem_req = 1 in RD_WAIT and WR_WAIT; mem_we = 1 only in WR_WAIT.
- Acceptance: an instruction is accepted in IDLE when valid_in=1 and flush=0. flush=1 in IDLE discards it, with no outputs next cycle. flush in a wait state is ignored; the access is already committed.
- Accept in IDLE, load (mem_to_reg_in=1, which takes priority if reg_to_mem_in is also 1):
  - register mem_addr = alu_result, plus reg_rd_in and ret_future_in;
  - next state RD_WAIT.
- Accept in IDLE, store:
  - register mem_addr = alu_result and mem_wdata = sw_data;
  - next state WR_WAIT.
- Accept in IDLE, non-memory op: next cycle wb_valid=1, wb_we=1, wb_data=alu_result, reg_rd_out=reg_rd_in. State stays IDLE, so back-to-back ALU ops run at 1 per cycle.
- RD_WAIT, mem_ready=1:
  - capture mem_rdata; state goes to IDLE next cycle.
  - Next cycle, ret_future=0: wb_valid=1, wb_we=1, wb_data=mem_rdata.
  - Next cycle, ret_future=1: ret_wb=1, PC_stack_pointer=mem_rdata, wb_valid=1, wb_we=0.
- WR_WAIT, mem_ready=1: next cycle wb_valid=1, wb_we=0, state IDLE.
- Latency: accept at cycle T, ready at T+k (k>=1), packet and stall=0 at T+k+1. A new instruction can be accepted at T+k+1.
- Timeout: the counter clears on entry to a wait state and increments each wait cycle with mem_ready=0. When it reaches MEM_TIMEOUT:
  - abort and return to IDLE;
  - next cycle mem_err=1, wb_valid=1, wb_we=0, ret_wb=0.
  - mem_ready in the same cycle as the limit wins over the timeout.
- mem_ready while in IDLE is ignored.
- Hold rules: wb_data, reg_rd_out, PC_stack_pointer, mem_addr and mem_wdata hold their last values when not updated. wb_valid, ret_wb and mem_err are single-cycle pulses.

Test Plan:
- ALU pass: valid_in with alu_result=0x1234, reg_rd_in=5 for 3 consecutive cycles -> wb_valid=1, wb_we=1, wb_data=0x1234, reg_rd_out=5 one cycle later each time; stall stays 0.
- Load with wait: load at addr 0x0040, mem_ready held low 2 cycles then high with mem_rdata=0xBEEF -> mem_req=1, mem_addr=0x0040 for 3 cycles; stall high for 3 cycles; next cycle wb_data=0xBEEF, wb_we=1.
- Return pop: load with ret_future_in=1, mem_rdata=0x0123 -> ret_wb=1 and PC_stack_pointer=0x0123 for one cycle; wb_we=0.
- Store: addr 0x0010, sw_data=0x00AA, mem_ready high on first wait cycle -> mem_we=1, mem_wdata=0x00AA for 1 cycle; then wb_valid=1, wb_we=0.
- Timeout: load with mem_ready never asserted -> mem_req drops after 15 wait cycles; mem_err pulses once; state returns to IDLE.
- Reset/flush: rst_n low mid-RD_WAIT -> all outputs 0 immediately. flush=1 with valid_in in IDLE -> no wb_valid and no mem_req.
